// File: rtl/maze_pkg.sv
// Shared encodings for the maze carver: directions, cell bit fields, FSM states, LFSR taps.
// Pure declarations, no latency, no backpressure.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  localparam int CELL_VISITED = 2;
  localparam int CELL_OPEN_E  = 1;
  localparam int CELL_OPEN_S  = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    PICK  = 3'd2,
    CARVE = 3'd3,
    POP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // First direction with its mask bit set, scanning upward (mod 4) from rot.
  function automatic logic [1:0] pick_dir(input logic [3:0] mask, input logic [1:0] rot);
    logic [1:0] d;
    logic [1:0] res;
    logic       found;
    res   = rot;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = rot + 2'(k);
      if (!found && mask[d]) begin
        res   = d;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Galois LFSR, advances every cycle; load substitutes SEED for a zero seed.
// Load takes effect on the next edge; no backpressure.
module maze_lfsr
  import maze_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [1:0]  rot
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    if (load) lfsr_d = (seed == 16'h0000) ? SEED : seed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rot = lfsr_q[1:0];

endmodule

// File: rtl/maze_dfs_carver.sv
// DFS backtracker maze carver: done 5N-3 edges after accepted start, rd_data 1-cycle latency.
// No backpressure (start ignored while busy); MAZE_CYCLE_COUNT_EN enables gen_cycles.
module maze_dfs_carver
  import maze_pkg::*;
#(
  parameter int          MAZE_W = 32,
  parameter int          MAZE_H = 16,
  parameter logic [15:0] SEED   = 16'hACE1,
  localparam int N  = MAZE_W * MAZE_H,
  localparam int XW = $clog2(MAZE_W),
  localparam int YW = $clog2(MAZE_H),
  localparam int AW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   seed,
  output logic          busy,
  output logic          done,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [2:0]    rd_data,
  output logic [AW-1:0] cells_carved,
  output logic [31:0]   gen_cycles
);

  localparam int IW = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(MAZE_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(MAZE_H - 1);
  localparam logic [XW:0]   W_X      = (XW + 1)'(MAZE_W);
  localparam logic [YW:0]   H_Y      = (YW + 1)'(MAZE_H);

  typedef logic [XW+YW-1:0] pos_t;

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(MAZE_W) + IW'(x);
  endfunction

  state_e        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [AW-1:0] carved_q, carved_d, idx_q, idx_d, sp_q, sp_d;
  logic [XW-1:0] cur_x_q, cur_x_d, nb_x;
  logic [YW-1:0] cur_y_q, cur_y_d, nb_y;
  dir_e          dir_q, dir_d;
  logic [2:0]    rd_data_q, rd_data_d;
  logic [2:0]    cell_q [N];
  logic [2:0]    cell_d [N];
  pos_t          stack_q [N];
  pos_t          stack_d [N];
  logic [3:0]    mask;
  logic [IW-1:0] cur_idx, nb_idx;
  logic [1:0]    rot;
  logic          start_ok;

  maze_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (seed),
    .rot   (rot)
  );

  // Unvisited in-bounds neighbours of the current cell, bit order {W,S,E,N}.
  always_comb begin
    mask = 4'b0000;
    if (cur_y_q != '0)    mask[DIR_N] = !cell_q[cell_idx(cur_x_q, cur_y_q - YW'(1))][CELL_VISITED];
    if (cur_x_q != X_MAX) mask[DIR_E] = !cell_q[cell_idx(cur_x_q + XW'(1), cur_y_q)][CELL_VISITED];
    if (cur_y_q != Y_MAX) mask[DIR_S] = !cell_q[cell_idx(cur_x_q, cur_y_q + YW'(1))][CELL_VISITED];
    if (cur_x_q != '0)    mask[DIR_W] = !cell_q[cell_idx(cur_x_q - XW'(1), cur_y_q)][CELL_VISITED];
  end

  always_comb begin
    nb_x = cur_x_q;
    nb_y = cur_y_q;
    case (dir_q)
      DIR_N: nb_y = cur_y_q - YW'(1);
      DIR_E: nb_x = cur_x_q + XW'(1);
      DIR_S: nb_y = cur_y_q + YW'(1);
      DIR_W: nb_x = cur_x_q - XW'(1);
    endcase
    cur_idx = cell_idx(cur_x_q, cur_y_q);
    nb_idx  = cell_idx(nb_x, nb_y);
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    carved_d = carved_q;
    idx_d    = idx_q;
    sp_d     = sp_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dir_d    = dir_q;
    start_ok = 1'b0;
    cell_d   = cell_q;
    stack_d  = stack_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = CLEAR;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          carved_d = '0;
          idx_d    = '0;
        end
      end
      CLEAR: begin
        cell_d[IW'(idx_q)] = 3'b000;
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          cell_d[0][CELL_VISITED] = 1'b1;
          cur_x_d = '0;
          cur_y_d = '0;
          state_d = PICK;
        end
      end
      PICK: begin
        dir_d = dir_e'(pick_dir(mask, rot));
        if (mask != 4'b0000) state_d = CARVE;
        else if (sp_q != '0) state_d = POP;
        else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      CARVE: begin
        // Each wall lives in exactly one cell: the west/north one of the pair.
        case (dir_q)
          DIR_N: cell_d[nb_idx][CELL_OPEN_S]  = 1'b1;
          DIR_E: cell_d[cur_idx][CELL_OPEN_E] = 1'b1;
          DIR_S: cell_d[cur_idx][CELL_OPEN_S] = 1'b1;
          DIR_W: cell_d[nb_idx][CELL_OPEN_E]  = 1'b1;
        endcase
        cell_d[nb_idx][CELL_VISITED] = 1'b1;
        stack_d[IW'(sp_q)] = {cur_x_q, cur_y_q};
        sp_d     = sp_q + AW'(1);
        cur_x_d  = nb_x;
        cur_y_d  = nb_y;
        carved_d = carved_q + AW'(1);
        state_d  = PICK;
      end
      POP: begin
        sp_d = sp_q - AW'(1);
        {cur_x_d, cur_y_d} = stack_q[IW'(sp_q - AW'(1))];
        state_d = PICK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data_d = 3'b000;
    if (({1'b0, rd_x} < W_X) && ({1'b0, rd_y} < H_Y)) rd_data_d = cell_q[cell_idx(rd_x, rd_y)];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      carved_q  <= '0;
      idx_q     <= '0;
      sp_q      <= '0;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      dir_q     <= DIR_N;
      rd_data_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      carved_q  <= carved_d;
      idx_q     <= idx_d;
      sp_q      <= sp_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      dir_q     <= dir_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Cell and stack storage are never reset; CLEAR initialises what matters.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cell_q  <= cell_d;
      stack_q <= stack_d;
    end
  end

`ifdef MAZE_CYCLE_COUNT_EN
  logic [31:0] gen_cycles_q, gen_cycles_d;

  always_comb begin
    gen_cycles_d = gen_cycles_q;
    if (start_ok)    gen_cycles_d = '0;
    else if (busy_q) gen_cycles_d = gen_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gen_cycles_q <= '0;
    else        gen_cycles_q <= gen_cycles_d;
  end

  assign gen_cycles = gen_cycles_q;
`else
  assign gen_cycles = 32'd0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign rd_data      = rd_data_q;
  assign cells_carved = carved_q;

endmodule

// File: tb/tb_maze_dfs_carver.sv
// Bench for maze_dfs_carver: 4x4, default 32x16 and 5x3 instances against a behavioural DFS model.
module tb_maze_dfs_carver;

  logic clk;
  logic rst_n;

  logic        start_s, busy_s, done_s;
  logic [15:0] seed_s;
  logic [1:0]  rdx_s, rdy_s;
  logic [2:0]  rdd_s;
  logic [4:0]  cc_s;
  logic [31:0] gc_s;

  logic        start_l, busy_l, done_l;
  logic [15:0] seed_l;
  logic [4:0]  rdx_l;
  logic [3:0]  rdy_l;
  logic [2:0]  rdd_l;
  logic [9:0]  cc_l;
  logic [31:0] gc_l;

  logic        start_o, busy_o, done_o;
  logic [15:0] seed_o;
  logic [2:0]  rdx_o;
  logic [1:0]  rdy_o;
  logic [2:0]  rdd_o;
  logic [3:0]  cc_o;
  logic [31:0] gc_o;

  maze_dfs_carver #(.MAZE_W(4), .MAZE_H(4)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .seed(seed_s), .busy(busy_s), .done(done_s),
    .rd_x(rdx_s), .rd_y(rdy_s), .rd_data(rdd_s), .cells_carved(cc_s), .gen_cycles(gc_s)
  );

  maze_dfs_carver u_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .seed(seed_l), .busy(busy_l), .done(done_l),
    .rd_x(rdx_l), .rd_y(rdy_l), .rd_data(rdd_l), .cells_carved(cc_l), .gen_cycles(gc_l)
  );

  maze_dfs_carver #(.MAZE_W(5), .MAZE_H(3)) u_o (
    .clk(clk), .rst_n(rst_n), .start(start_o), .seed(seed_o), .busy(busy_o), .done(done_o),
    .rd_x(rdx_o), .rd_y(rdy_o), .rd_data(rdd_o), .cells_carved(cc_o), .gen_cycles(gc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  int sel;
  int cur_w;
  int cur_h;

  logic       busy_m, done_m;
  logic [2:0] rdd_m;
  int         cc_m, gc_m;

  logic [2:0] exp_cell [512];
  logic [2:0] got      [512];
  logic [2:0] map_a    [512];

  always_comb begin
    case (sel)
      0: begin busy_m = busy_s; done_m = done_s; rdd_m = rdd_s; cc_m = int'(cc_s); gc_m = int'(gc_s); end
      1: begin busy_m = busy_l; done_m = done_l; rdd_m = rdd_l; cc_m = int'(cc_l); gc_m = int'(gc_l); end
      default: begin busy_m = busy_o; done_m = done_o; rdd_m = rdd_o; cc_m = int'(cc_o); gc_m = int'(gc_o); end
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v, input logic [15:0] sd);
    case (sel)
      0: begin start_s = v; seed_s = sd; end
      1: begin start_l = v; seed_l = sd; end
      default: begin start_o = v; seed_o = sd; end
    endcase
  endtask

  task automatic set_rd(input int x, input int y);
    case (sel)
      0: begin rdx_s = 2'(x); rdy_s = 2'(y); end
      1: begin rdx_l = 5'(x); rdy_l = 4'(y); end
      default: begin rdx_o = 3'(x); rdy_o = 2'(y); end
    endcase
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Recursive backtracker from (0,0); the LFSR moves once per clock, one clock per
  // PICK/CARVE/POP decision, after N clear cycles that follow the seed load.
  task automatic model_maze(input int w, input int h, input logic [15:0] sd);
    int dx [4] = '{0, 1, 0, -1};
    int dy [4] = '{-1, 0, 1, 0};
    bit vis [512];
    int sx[$];
    int sy[$];
    int n, cx, cy, d, nb, cu;
    logic [15:0] l;
    n = w * h;
    for (int i = 0; i < 512; i++) begin
      exp_cell[i] = 3'b000;
      vis[i] = 1'b0;
    end
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    repeat (n) l = lstep(l);
    cx = 0;
    cy = 0;
    vis[0] = 1'b1;
    forever begin
      d = -1;
      for (int k = 0; k < 4; k++) begin
        int dd, tx, ty;
        dd = (int'(l[1:0]) + k) % 4;
        tx = cx + dx[dd];
        ty = cy + dy[dd];
        if (d < 0 && tx >= 0 && tx < w && ty >= 0 && ty < h && !vis[ty * w + tx]) d = dd;
      end
      l = lstep(l);
      if (d >= 0) begin
        cu = cy * w + cx;
        nb = (cy + dy[d]) * w + cx + dx[d];
        case (d)
          0: exp_cell[nb][0] = 1'b1;
          1: exp_cell[cu][1] = 1'b1;
          2: exp_cell[cu][0] = 1'b1;
          default: exp_cell[nb][1] = 1'b1;
        endcase
        vis[nb] = 1'b1;
        sx.push_back(cx);
        sy.push_back(cy);
        cx = cx + dx[d];
        cy = cy + dy[d];
        l = lstep(l);
      end else if (sx.size() > 0) begin
        cx = sx.pop_back();
        cy = sy.pop_back();
        l = lstep(l);
      end else begin
        break;
      end
    end
    for (int i = 0; i < n; i++) exp_cell[i][2] = vis[i];
  endtask

  task automatic read_map(input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        set_rd(x, y);
        @(posedge clk); #1;
        got[y * w + x] = rdd_m;
      end
    end
  endtask

  function automatic int diff_exp(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (got[i] !== exp_cell[i]) c++;
    return c;
  endfunction

  function automatic int diff_a(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (got[i] !== map_a[i]) c++;
    return c;
  endfunction

  task automatic check_tree(input int w, input int h, input string tag);
    int n, unvis, walls, border, reach, c, x, y;
    int q[$];
    bit seen [512];
    n = w * h;
    unvis = 0; walls = 0; border = 0;
    for (int i = 0; i < n; i++) begin
      seen[i] = 1'b0;
      if (got[i][2] !== 1'b1) unvis++;
      walls += int'(got[i][1]) + int'(got[i][0]);
      if ((i % w) == w - 1 && got[i][1]) border++;
      if ((i / w) == h - 1 && got[i][0]) border++;
    end
    seen[0] = 1'b1;
    reach = 1;
    q.push_back(0);
    while (q.size() > 0) begin
      c = q.pop_front();
      x = c % w;
      y = c / w;
      for (int d = 0; d < 4; d++) begin
        int t;
        t = -1;
        case (d)
          0: if (y > 0 && got[c - w][0]) t = c - w;
          1: if (x < w - 1 && got[c][1]) t = c + 1;
          2: if (y < h - 1 && got[c][0]) t = c + w;
          default: if (x > 0 && got[c - 1][1]) t = c - 1;
        endcase
        if (t >= 0 && !seen[t]) begin
          seen[t] = 1'b1;
          reach++;
          q.push_back(t);
        end
      end
    end
    check({tag, "_unvisited"}, unvis, 0);
    check({tag, "_open_walls"}, walls, n - 1);
    check({tag, "_border_open"}, border, 0);
    check({tag, "_bfs_reach"}, reach, n);
  endtask

  task automatic run_gen(input logic [15:0] sd, input bit poke, output int edges);
    set_start(1'b1, sd);
    @(posedge clk); #1;
    set_start(1'b0, sd);
    check("busy_after_start", int'(busy_m), 1);
    edges = 0;
    while (done_m !== 1'b1 && edges < 6000) begin
      @(posedge clk); #1;
      edges++;
      set_start(poke && (edges % 200 == 3), 16'($urandom));
    end
    set_start(1'b0, sd);
  endtask

  task automatic gen_and_check(input logic [15:0] sd, input bit poke, input string tag);
    int edges, n, exp_gc;
    n = cur_w * cur_h;
    run_gen(sd, poke, edges);
    check({tag, "_done_edge"}, edges, 5 * n - 3);
    check({tag, "_busy_low"}, int'(busy_m), 0);
    check({tag, "_done_high"}, int'(done_m), 1);
    check({tag, "_cells_carved"}, cc_m, n - 1);
`ifdef MAZE_CYCLE_COUNT_EN
    exp_gc = 5 * n - 3;
`else
    exp_gc = 0;
`endif
    check({tag, "_gen_cycles"}, gc_m, exp_gc);
    model_maze(cur_w, cur_h, sd);
    read_map(cur_w, cur_h);
    check({tag, "_map_vs_model"}, diff_exp(n), 0);
    check_tree(cur_w, cur_h, tag);
  endtask

  initial begin
    logic [15:0] rs;
    int a_idx, b_idx;
    tests = 0;
    fails = 0;
    sel = 0; cur_w = 4; cur_h = 4;
    rst_n = 1'b0;
    start_s = 0; start_l = 0; start_o = 0;
    seed_s = 0; seed_l = 0; seed_o = 0;
    rdx_s = 0; rdy_s = 0; rdx_l = 0; rdy_l = 0; rdx_o = 0; rdy_o = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_m), 0);
    check("rst_done", int'(done_m), 0);
    check("rst_cells_carved", cc_m, 0);
    check("rst_rd_data", int'(rdd_m), 0);
    check("rst_gen_cycles", gc_m, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    gen_and_check(16'h0001, 1'b0, "s4_seed1");
    for (int i = 0; i < 16; i++) map_a[i] = got[i];
    gen_and_check(16'h0001, 1'b0, "s4_seed1_again");
    check("s4_same_seed_same_map", diff_a(16), 0);

    gen_and_check(16'h0000, 1'b0, "s4_seed0");
    for (int i = 0; i < 16; i++) map_a[i] = got[i];
    gen_and_check(16'hACE1, 1'b0, "s4_seedACE1");
    check("s4_seed0_eq_default", diff_a(16), 0);
    gen_and_check(16'h1234, 1'b0, "s4_seed1234");
    check("s4_seed1234_differs", int'(diff_a(16) != 0), 1);

    for (int r = 0; r < 3; r++) begin
      rs = 16'($urandom);
      gen_and_check(rs, 1'b0, "s4_rand");
    end

    // Reset held for the single edge 40 of a run.
    set_start(1'b1, 16'h00A5);
    @(posedge clk); #1;
    set_start(1'b0, 16'h00A5);
    repeat (39) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", int'(busy_m), 0);
    check("midrst_done", int'(done_m), 0);
    check("midrst_cells_carved", cc_m, 0);
    rs = 16'($urandom);
    gen_and_check(rs, 1'b0, "s4_after_rst");

    sel = 1; cur_w = 32; cur_h = 16;
    rs = 16'($urandom);
    gen_and_check(rs, 1'b1, "l32x16_poked");

    sel = 2; cur_w = 5; cur_h = 3;
    rs = 16'($urandom);
    gen_and_check(rs, 1'b0, "o5x3");
    a_idx = 14;
    b_idx = 0;
    for (int i = 13; i >= 0; i--) if (exp_cell[i] !== exp_cell[a_idx]) b_idx = i;
    set_rd(a_idx % 5, a_idx / 5);
    @(posedge clk); #1;
    check("lat_first", int'(rdd_m), int'(exp_cell[a_idx]));
    set_rd(b_idx % 5, b_idx / 5);
    #1;
    check("lat_hold_before_edge", int'(rdd_m), int'(exp_cell[a_idx]));
    @(posedge clk); #1;
    check("lat_after_edge", int'(rdd_m), int'(exp_cell[b_idx]));
    set_rd(5, 0);
    @(posedge clk); #1;
    check("oor_x", int'(rdd_m), 0);
    set_rd(2, 1);
    @(posedge clk); #1;
    check("inrange_again", int'(rdd_m), int'(exp_cell[7]));
    set_rd(0, 3);
    @(posedge clk); #1;
    check("oor_y", int'(rdd_m), 0);
    set_rd(7, 3);
    @(posedge clk); #1;
    check("oor_xy", int'(rdd_m), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maze_dfs_carver.md
Name: maze_dfs_carver

Overview:
Parametrised maze generator using a randomised depth-first recursive backtracker with an explicit stack. It carves a perfect maze (spanning tree, exactly one path between any two cells) on a MAZE_W x MAZE_H cell grid. An LFSR drives direction choice. A registered read port exposes each cell's open-wall bits to the display/render logic.

Parameters:
MAZE_W, 32, grid width in cells (>=2)
MAZE_H, 16, grid height in cells (>=2)
SEED, 16'hACE1, default LFSR seed, used when the seed port is 0 (must be nonzero)
Derived: N = MAZE_W*MAZE_H; XW = clog2(MAZE_W); YW = clog2(MAZE_H); AW = clog2(N+1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin generation; sampled only in IDLE or DONE
seed  in  16  LFSR seed, latched when start is accepted; 0 selects SEED
busy  out  1  high from accepted start until DONE
done  out  1  high in DONE, cleared by next accepted start or reset
rd_x  in  XW  read column
rd_y  in  YW  read row
rd_data  out  3  {visited, open_e, open_s} of (rd_x,rd_y), 1-cycle latency
cells_carved  out  AW  count of CARVE cycles since start
gen_cycles  out  32  see Optional Feature

Behaviour:
- Cell storage is a register array of N x 3 bits. open_e removes the wall to x+1. open_s removes the wall to y+1. West and north walls are read from the neighbour.
- Reset: state=IDLE; busy=0, done=0, cells_carved=0, rd_data=0, sp=0, cur=(0,0), LFSR=SEED. Cell array is not reset; its contents are undefined until CLEAR completes.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every cycle outside reset.
- States:
  - IDLE/DONE:
    - start=1 latches seed (0 -> SEED) into the LFSR.
    - busy=1, done=0, cells_carved=0, idx=0.
    - Next state: CLEAR.
  - CLEAR (N cycles):
    - Writes cell[idx]=3'b000, idx++.
    - On idx=N-1, also sets cell(0,0).visited=1 and cur=(0,0).
    - Next state: PICK.
  - PICK (1 cycle):
    - Builds mask[3:0] {W,S,E,N} of in-bounds, unvisited neighbours of cur.
    - rot = lfsr[1:0]. Scans d=(rot+k) mod 4 for k=0..3 (N=0,E=1,S=2,W=3) and takes the first d with mask[d]=1.
    - mask!=0 -> CARVE.
    - mask==0 and sp!=0 -> POP.
    - mask==0 and sp==0 -> DONE with busy=0, done=1.
  - CARVE (1 cycle):
    - Opens the shared wall: N sets neighbour.open_s; E sets cur.open_e; S sets cur.open_s; W sets neighbour.open_e.
    - Sets neighbour.visited, push cur (stack[sp]=cur, sp++), cur=neighbour, cells_carved++.
    - Next state: PICK.
  - POP (1 cycle): sp--, cur=stack[sp-1]. Next state: PICK.
- Stack: N entries of {x,y}, sp width AW. Overflow is impossible (at most N-1 pushes).
- Timing is deterministic:
  - CARVE and POP each occur N-1 times; PICK occurs 2N-1 times.
  - done rises at rising edge 5N-3 after the edge that accepted start.
- start while busy is ignored. start in DONE restarts generation.
- Read port:
  - rd_data registers cell[rd_y*MAZE_W+rd_x] every cycle.
  - Out-of-range coordinates return 0.
  - Data is only meaningful when done=1; reading while busy returns the live array without corrupting generation.
- rst_n=0 mid-generation returns to IDLE within one edge. The partial array is kept but undefined; the next start regenerates fully.

Optional Feature:
MAZE_CYCLE_COUNT_EN
- Defined: gen_cycles clears on accepted start, increments every cycle while busy, and holds at DONE (expected 5N-3).
- Undefined: gen_cycles is tied to 0 and the counter is not synthesised.

Decomposition:
- Package maze_pkg holds:
  - direction encoding DIR_N/E/S/W (2-bit)
  - cell field indices CELL_VISITED=2, CELL_OPEN_E=1, CELL_OPEN_S=0
  - state encoding IDLE/CLEAR/PICK/CARVE/POP/DONE
  - LFSR_TAPS=16'hB400
- Sub-module maze_lfsr (16-bit Galois LFSR with load/seed-substitution) is instantiated once.

Test Plan:
- 4x4, seed=16'h0001: pulse start -> busy next edge; done at edge 77 (5*16-3); cells_carved=15; gen_cycles=77 with MAZE_CYCLE_COUNT_EN.
- After done, read all 16 cells -> all visited=1; total open walls=15; BFS from (0,0) over open walls reaches all 16 cells; no open_e on x=3 and no open_s on y=3.
- Same seed twice -> identical rd_data maps. seed=16'h0000 vs seed=SEED -> identical maps. seed=16'h1234 -> differs from SEED map.
- Default 32x16: start -> done at edge 2557; 511 open walls; spanning-tree check passes; start pulses while busy do not change timing.
- rst_n=0 for 1 cycle at edge 40 of a 4x4 run -> busy=0, done=0, cells_carved=0 next edge. A new start completes in 77 edges with a valid maze.
- rd_x=MAZE_W or rd_y=MAZE_H -> rd_data=3'b000 one cycle later. Changing rd_x/rd_y -> rd_data updates with exactly one cycle latency.
